// File: rtl/backend_cmd_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : backend_cmd_buffer_pkg
// Description : Shared backend command constants and types. Holds the
//               backend command width and encodings, and the state type of
//               the command buffer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package backend_cmd_buffer_pkg;

    // Backend command width and encodings
    localparam int BECMDWidth = 2;

    localparam logic [BECMDWidth-1:0] BECMD_Update  = 2'd0;
    localparam logic [BECMDWidth-1:0] BECMD_Append  = 2'd1;
    localparam logic [BECMDWidth-1:0] BECMD_Read    = 2'd2;
    localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = 2'd3;

    // Buffer controller: IDLE while empty, ISSUE while a head entry is offered
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } becmd_buf_state_t;

endpackage : backend_cmd_buffer_pkg
`default_nettype wire

// File: rtl/becmd_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : becmd_fifo_mem
// Description : Command buffer storage. Depth x Width register array with
//               one synchronous write port and one asynchronous read port.
//               Storage is not reset; validity is tracked by the parent.
// Ports       : Clock       - rising-edge clock
//               WriteEnable - write WriteData at WriteAddr on the clock edge
//               WriteAddr   - write index
//               WriteData   - write word
//               ReadAddr    - read index
//               ReadData    - combinational read word
// Revision    : 1.0 - initial release
// ============================================================================
module becmd_fifo_mem #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                     Clock,
    input  logic                     WriteEnable,
    input  logic [$clog2(Depth)-1:0] WriteAddr,
    input  logic [Width-1:0]         WriteData,
    input  logic [$clog2(Depth)-1:0] ReadAddr,
    output logic [Width-1:0]         ReadData
);

    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge Clock) begin
        if (WriteEnable) begin
            r_mem[WriteAddr] <= WriteData;
        end
    end

    assign ReadData = r_mem[ReadAddr];

endmodule : becmd_fifo_mem
`default_nettype wire

// File: rtl/backend_cmd_buffer.sv
`default_nettype none
// ============================================================================
// Module      : backend_cmd_buffer
// Description : Strict-FIFO buffer between the ORAM frontend and the backend
//               controller. Entries are {Command, PAddr, CurrentLeaf,
//               RemappedLeaf}. The head entry is offered on CommandRequest;
//               a CommandDone pulse pops it, and a registered ReturnValid
//               pulse with the popped PAddr follows one cycle later.
//               Optional statistics counters are compiled in when the macro
//               BECMD_BUF_STATS_EN is defined; otherwise they read 0.
// Ports       : Clock, Reset (async, active-low)
//               InCommand/InPAddr/InCurrentLeaf/InRemappedLeaf/InValid/InReady
//                   - frontend push interface
//               Command/PAddr/CurrentLeaf/RemappedLeaf/CommandRequest/
//               CommandDone - head entry to the backend controller
//               ReturnValid/ReturnPAddr - completion pulse to the frontend
//               Count - occupancy
//               StatIssued/StatStallCycles - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module backend_cmd_buffer #(
    parameter int ORAMU      = 32,
    parameter int ORAML      = 32,
    parameter int BECMDWidth = backend_cmd_buffer_pkg::BECMDWidth,
    parameter int Depth      = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [BECMDWidth-1:0]    InCommand,
    input  logic [ORAMU-1:0]         InPAddr,
    input  logic [ORAML-1:0]         InCurrentLeaf,
    input  logic [ORAML-1:0]         InRemappedLeaf,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [BECMDWidth-1:0]    Command,
    output logic [ORAMU-1:0]         PAddr,
    output logic [ORAML-1:0]         CurrentLeaf,
    output logic [ORAML-1:0]         RemappedLeaf,
    output logic                     CommandRequest,
    input  logic                     CommandDone,
    output logic                     ReturnValid,
    output logic [ORAMU-1:0]         ReturnPAddr,
    output logic [$clog2(Depth):0]   Count,
    output logic [31:0]              StatIssued,
    output logic [31:0]              StatStallCycles
);

    import backend_cmd_buffer_pkg::*;

    localparam int c_PtrWidth   = $clog2(Depth);
    localparam int c_CountWidth = c_PtrWidth + 1;
    localparam int c_EntryWidth = BECMDWidth + ORAMU + 2 * ORAML;

    localparam logic [c_CountWidth-1:0] c_CountFull = c_CountWidth'(Depth);
    localparam logic [c_CountWidth-1:0] c_CountOne  = c_CountWidth'(1);
    localparam logic [c_PtrWidth-1:0]   c_PtrOne    = c_PtrWidth'(1);

    logic [c_PtrWidth-1:0]   r_head;
    logic [c_PtrWidth-1:0]   r_tail;
    logic [c_CountWidth-1:0] r_count;
    becmd_buf_state_t        r_state;
    becmd_buf_state_t        w_nextState;
    logic                    r_returnValid;
    logic [ORAMU-1:0]        r_returnPAddr;

    logic                    w_push;
    logic                    w_pop;
    logic [c_EntryWidth-1:0] w_writeEntry;
    logic [c_EntryWidth-1:0] w_headEntry;

    // Handshakes. InReady depends only on registered occupancy, so a full
    // buffer cannot accept an entry even in a cycle where it pops.
    assign InReady        = (r_count != c_CountFull);
    // ISSUE is held exactly while Count is non-zero
    assign CommandRequest = (r_state == ST_ISSUE);
    assign w_push         = InValid && InReady;
    assign w_pop          = CommandDone && CommandRequest;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    assign w_writeEntry = {InCommand, InPAddr, InCurrentLeaf, InRemappedLeaf};

    becmd_fifo_mem #(
        .Depth (Depth),
        .Width (c_EntryWidth)
    ) u_mem (
        .Clock       (Clock),
        .WriteEnable (w_push),
        .WriteAddr   (r_tail),
        .WriteData   (w_writeEntry),
        .ReadAddr    (r_head),
        .ReadData    (w_headEntry)
    );

    assign {Command, PAddr, CurrentLeaf, RemappedLeaf} = w_headEntry;

    // ------------------------------------------------------------------------
    // Pointers and occupancy. Depth is a power of two, so the pointers wrap
    // naturally at Depth-1 -> 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PtrOne;
            end
            if (w_pop) begin
                r_head <= r_head + c_PtrOne;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CountOne;
                2'b01:   r_count <= r_count - c_CountOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Last entry leaves with nothing arriving behind it
                if (w_pop && !w_push && (r_count == c_CountOne)) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Completion return, registered one cycle after the pop
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_returnValid <= 1'b0;
            r_returnPAddr <= '0;
        end else begin
            r_returnValid <= w_pop;
            if (w_pop) begin
                r_returnPAddr <= PAddr;
            end
        end
    end

    assign ReturnValid = r_returnValid;
    assign ReturnPAddr = r_returnPAddr;
    assign Count       = r_count;

    // ------------------------------------------------------------------------
    // Statistics (wrap at 2^32)
    // ------------------------------------------------------------------------
`ifdef BECMD_BUF_STATS_EN
    logic [31:0] r_statIssued;
    logic [31:0] r_statStallCycles;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_statIssued      <= '0;
            r_statStallCycles <= '0;
        end else begin
            if (w_pop) begin
                r_statIssued <= r_statIssued + 32'd1;
            end
            if (CommandRequest && !CommandDone) begin
                r_statStallCycles <= r_statStallCycles + 32'd1;
            end
        end
    end

    assign StatIssued      = r_statIssued;
    assign StatStallCycles = r_statStallCycles;
`else
    assign StatIssued      = 32'd0;
    assign StatStallCycles = 32'd0;
`endif

endmodule : backend_cmd_buffer
`default_nettype wire

// File: tb/tb_backend_cmd_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_backend_cmd_buffer
// Description : Self-checking bench for backend_cmd_buffer (Depth=4).
//               Table of single-cycle vectors plus hand-written sequences for
//               streaming wrap, mid-stream reset and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_backend_cmd_buffer;

    import backend_cmd_buffer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  InCommand;
    logic [31:0] InPAddr, InCurrentLeaf, InRemappedLeaf;
    logic        InValid, InReady;
    logic [1:0]  Command;
    logic [31:0] PAddr, CurrentLeaf, RemappedLeaf;
    logic        CommandRequest, CommandDone;
    logic        ReturnValid;
    logic [31:0] ReturnPAddr;
    logic [2:0]  Count;
    logic [31:0] StatIssued, StatStallCycles;

    int checks   = 0;
    int failures = 0;

    backend_cmd_buffer #(
        .ORAMU(32), .ORAML(32), .BECMDWidth(2), .Depth(4)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InCommand      (InCommand),
        .InPAddr        (InPAddr),
        .InCurrentLeaf  (InCurrentLeaf),
        .InRemappedLeaf (InRemappedLeaf),
        .InValid        (InValid),
        .InReady        (InReady),
        .Command        (Command),
        .PAddr          (PAddr),
        .CurrentLeaf    (CurrentLeaf),
        .RemappedLeaf   (RemappedLeaf),
        .CommandRequest (CommandRequest),
        .CommandDone    (CommandDone),
        .ReturnValid    (ReturnValid),
        .ReturnPAddr    (ReturnPAddr),
        .Count          (Count),
        .StatIssued     (StatIssued),
        .StatStallCycles(StatStallCycles)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        inValid;
        logic [1:0]  cmd;
        logic [31:0] paddr;
        logic [31:0] cur;
        logic [31:0] rem;
        logic        done;
        logic [2:0]  expCount;
        logic        expReady;
        logic        expReq;
        logic        expRv;
        logic [31:0] expRet;
        logic [1:0]  expCmd;
        logic [31:0] expPAddr;
        logic [31:0] expCur;
        logic [31:0] expRem;
    } vec_t;

    function automatic vec_t mkv(
        input logic v, input logic [1:0] c, input logic [31:0] p,
        input logic [31:0] cl, input logic [31:0] rl, input logic d,
        input logic [2:0] ec, input logic er, input logic eq, input logic ev,
        input logic [31:0] eret, input logic [1:0] ecmd, input logic [31:0] ep,
        input logic [31:0] ecl, input logic [31:0] erl);
        vec_t t;
        t.inValid = v;  t.cmd = c;  t.paddr = p;  t.cur = cl;  t.rem = rl;
        t.done = d;  t.expCount = ec;  t.expReady = er;  t.expReq = eq;
        t.expRv = ev;  t.expRet = eret;  t.expCmd = ecmd;  t.expPAddr = ep;
        t.expCur = ecl;  t.expRem = erl;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] p,
                         input logic [31:0] cl, input logic [31:0] rl, input logic d);
        @(negedge Clock);
        InValid = v;  InCommand = c;  InPAddr = p;
        InCurrentLeaf = cl;  InRemappedLeaf = rl;  CommandDone = d;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    vec_t vecs [14];

    initial begin
        // Single-cycle vectors: inputs for one edge, outputs just after it
        vecs[0]  = mkv(1, BECMD_Append,  32'h10, 5, 9, 0,  3'd1, 1, 1, 0, 0, BECMD_Append, 32'h10, 5, 9);
        vecs[1]  = mkv(0, 0, 0, 0, 0, 1,                   3'd0, 1, 0, 1, 32'h10, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 0, 0, 0, 0, 0,                   3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(0, 0, 0, 0, 0, 1,                   3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mkv(1, BECMD_Read,    32'h21, 32'h121, 32'h221, 0, 3'd1, 1, 1, 0, 0, BECMD_Read, 32'h21, 32'h121, 32'h221);
        vecs[5]  = mkv(1, BECMD_Update,  32'h22, 32'h122, 32'h222, 0, 3'd2, 1, 1, 0, 0, BECMD_Read, 32'h21, 32'h121, 32'h221);
        vecs[6]  = mkv(1, BECMD_Append,  32'h23, 32'h123, 32'h223, 0, 3'd3, 1, 1, 0, 0, BECMD_Read, 32'h21, 32'h121, 32'h221);
        vecs[7]  = mkv(1, BECMD_ReadRmv, 32'h24, 32'h124, 32'h224, 0, 3'd4, 0, 1, 0, 0, BECMD_Read, 32'h21, 32'h121, 32'h221);
        vecs[8]  = mkv(1, BECMD_Read,    32'h25, 32'h125, 32'h225, 0, 3'd4, 0, 1, 0, 0, BECMD_Read, 32'h21, 32'h121, 32'h221);
        vecs[9]  = mkv(1, BECMD_Read,    32'h26, 32'h126, 32'h226, 1, 3'd3, 1, 1, 1, 32'h21, BECMD_Update, 32'h22, 32'h122, 32'h222);
        vecs[10] = mkv(0, 0, 0, 0, 0, 1, 3'd2, 1, 1, 1, 32'h22, BECMD_Append,  32'h23, 32'h123, 32'h223);
        vecs[11] = mkv(0, 0, 0, 0, 0, 1, 3'd1, 1, 1, 1, 32'h23, BECMD_ReadRmv, 32'h24, 32'h124, 32'h224);
        vecs[12] = mkv(0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 32'h24, 0, 0, 0, 0);
        vecs[13] = mkv(0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0);

        Reset = 1'b0;  InValid = 0;  InCommand = 0;  InPAddr = 0;
        InCurrentLeaf = 0;  InRemappedLeaf = 0;  CommandDone = 0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_count", Count, 0);
        check("reset_ready", InReady, 1);
        check("reset_req", CommandRequest, 0);
        check("reset_rv", ReturnValid, 0);
        check("reset_stat_issued", StatIssued, 0);
        check("reset_stat_stall", StatStallCycles, 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].inValid, vecs[i].cmd, vecs[i].paddr, vecs[i].cur, vecs[i].rem, vecs[i].done);
            tick();
            check($sformatf("v%0d_count", i), Count, vecs[i].expCount);
            check($sformatf("v%0d_ready", i), InReady, vecs[i].expReady);
            check($sformatf("v%0d_req", i), CommandRequest, vecs[i].expReq);
            check($sformatf("v%0d_rv", i), ReturnValid, vecs[i].expRv);
            if (vecs[i].expRv)
                check($sformatf("v%0d_retpaddr", i), ReturnPAddr, vecs[i].expRet);
            if (vecs[i].expReq) begin
                check($sformatf("v%0d_cmd", i), Command, vecs[i].expCmd);
                check($sformatf("v%0d_paddr", i), PAddr, vecs[i].expPAddr);
                check($sformatf("v%0d_cur", i), CurrentLeaf, vecs[i].expCur);
                check($sformatf("v%0d_rem", i), RemappedLeaf, vecs[i].expRem);
            end
        end

        // Streaming push+pop every cycle, PAddr 0..9, wrapping the pointers
        drive(1, BECMD_Read, 0, 0, 0, 0);
        tick();
        check("stream_first_count", Count, 1);
        for (int i = 1; i < 10; i++) begin
            drive(1, BECMD_Read, i, 0, 0, 1);
            tick();
            check($sformatf("stream%0d_count", i), Count, 1);
            check($sformatf("stream%0d_rv", i), ReturnValid, 1);
            check($sformatf("stream%0d_ret", i), ReturnPAddr, i - 1);
            check($sformatf("stream%0d_head", i), PAddr, i);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("stream_last_ret", ReturnPAddr, 9);
        check("stream_last_rv", ReturnValid, 1);
        check("stream_last_count", Count, 0);

        // Mid-stream reset: two entries, one pop in flight, then Reset low
        drive(1, BECMD_Update, 32'h40, 0, 0, 0);
        tick();
        drive(1, BECMD_Update, 32'h41, 0, 0, 0);
        tick();
        check("rst_pre_count", Count, 2);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("rst_pre_rv", ReturnValid, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("rst_mid_count", Count, 0);
        check("rst_mid_req", CommandRequest, 0);
        check("rst_mid_rv", ReturnValid, 0);
        check("rst_mid_ready", InReady, 1);
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            tick();
            check($sformatf("rst_spur%0d_count", i), Count, 0);
            check($sformatf("rst_spur%0d_rv", i), ReturnValid, 0);
            check($sformatf("rst_spur%0d_req", i), CommandRequest, 0);
        end

        // Statistics: one entry stalled for 3 cycles, then completed
        drive(1, BECMD_Read, 32'h55, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("stats_rv", ReturnValid, 1);
        check("stats_ret", ReturnPAddr, 32'h55);
`ifdef BECMD_BUF_STATS_EN
        check("stat_stall", StatStallCycles, 3);
        check("stat_issued", StatIssued, 1);
`else
        check("stat_stall", StatStallCycles, 0);
        check("stat_issued", StatIssued, 0);
`endif
        drive(0, 0, 0, 0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_backend_cmd_buffer
`default_nettype wire

// File: doc/backend_cmd_buffer.md
BACKEND_CMD_BUFFER -- requirements
Module: backend_cmd_buffer

Interface
REQ-001 Parameter ORAMU, default 32, program-address width.
REQ-002 Parameter ORAML, default 32, leaf width.
REQ-003 Parameter BECMDWidth, default 2, backend command width.
REQ-004 Parameter Depth, default 4, FIFO entries; power of two, >=2.
REQ-005 Clock  in  1  single clock; all state on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 InCommand  in  BECMDWidth  frontend command.
REQ-008 InPAddr  in  ORAMU  frontend program address.
REQ-009 InCurrentLeaf, InRemappedLeaf  in  ORAML each  frontend leaves.
REQ-010 InValid  in  1  frontend entry valid.
REQ-011 InReady  out  1  buffer accepts an entry.
REQ-012 Command, PAddr, CurrentLeaf, RemappedLeaf  out  BECMDWidth/ORAMU/ORAML/ORAML  head entry to the backend controller.
REQ-013 CommandRequest  out  1  head entry valid.
REQ-014 CommandDone  in  1  backend completed head entry; single-cycle pulse.
REQ-015 ReturnValid  out  1  one-cycle completion pulse to the frontend.
REQ-016 ReturnPAddr  out  ORAMU  PAddr of the completed entry.
REQ-017 Count  out  log2(Depth)+1  occupancy.
REQ-018 StatIssued, StatStallCycles  out  32 each  statistics; see REQ-037.

Function
REQ-019 Push when InValid & InReady; the entry is written at the tail and the tail pointer increments modulo Depth.
REQ-020 InReady = (Count != Depth), decoded from registered Count only; there is no same-cycle pop-to-push pass-through.
REQ-021 CommandRequest = (Count != 0); the head fields are driven from storage at the head pointer and are stable while CommandRequest is high.
REQ-022 Push into an empty buffer: CommandRequest rises exactly one cycle after the push edge.
REQ-023 Pop when CommandDone & CommandRequest; the head pointer increments modulo Depth.
REQ-024 CommandDone while CommandRequest=0 is ignored: no pop, no ReturnValid, no state change.
REQ-025 Push and pop in the same cycle: Count unchanged, both pointers advance.
REQ-026 ReturnValid is registered: it is high in the cycle after a pop, with ReturnPAddr holding the popped entry's PAddr.
REQ-027 The FSM has two states. IDLE (Count=0) goes to ISSUE on push. ISSUE goes to IDLE on a pop with Count=1 and no simultaneous push; otherwise it stays.
REQ-028 Count arithmetic is exact at every boundary: no increment past Depth, no decrement below 0.
REQ-029 Pointer wrap from Depth-1 to 0 is seamless, with order preserved FIFO-strict.
REQ-030 Entries are never reordered, and Append commands receive no special treatment.

Reset
REQ-031 Asserting Reset at any time, including mid-operation, flushes the buffer; in-flight entries are discarded without a ReturnValid.
REQ-032 Reset values: Count=0, pointers=0, state=IDLE, CommandRequest=0, ReturnValid=0, InReady=1, statistics=0.
REQ-033 After reset the head data outputs are don't-care and are not checked while CommandRequest=0.
REQ-034 A CommandDone arriving in the first cycle after deassertion is ignored per REQ-024.

Configuration
REQ-035 Macro BECMD_BUF_STATS_EN selects whether statistics are compiled in.
REQ-036 Without the macro, StatIssued and StatStallCycles are tied to 0 and no counter flops are synthesized.
REQ-037 With the macro:
- StatIssued increments on each pop.
- StatStallCycles increments on each cycle with CommandRequest=1 and CommandDone=0.
- Both counters wrap at 2^32.

Structure
REQ-038 The BECMD encodings (including BECMD_Append) and BECMDWidth live in the shared package, together with the other backend command constants.
REQ-039 Storage is one sub-module, becmd_fifo_mem: Depth x (BECMDWidth+ORAMU+2*ORAML), one write port, one asynchronous read port. Pointer, count and FSM logic stay in the parent.

Verification
REQ-040 Push {Append, PAddr=0x10, leaves 5/9} into an empty buffer -> CommandRequest=1 next cycle with those values; CommandDone -> ReturnValid=1 next cycle with ReturnPAddr=0x10; Count returns to 0.
REQ-041 Push Depth=4 entries with CommandDone held low -> InReady=0 at Count=4; a fifth InValid is not accepted and Count stays 4.
REQ-042 At Count=4, assert CommandDone and InValid together -> no push in that cycle; next cycle Count=3 and InReady=1.
REQ-043 Streaming push+pop each cycle for 10 entries, PAddr 0..9 -> pointers wrap, ReturnPAddr sequence is 0..9, Count constant.
REQ-044 Count=2, then Reset low mid-stream, then 3 spurious CommandDone pulses after release -> Count=0, no ReturnValid.
REQ-045 With BECMD_BUF_STATS_EN, a 3-cycle stall then done -> StatStallCycles=3, StatIssued=1; without the macro both read 0.
